// File: rtl/tpu_tile_sequencer_if.sv
// Bundle between the tile sequencer and its surroundings: host command/status,
// A/B global-buffer read ports, C write port, and the systolic-array side.
//   master : host / buffers / array model (drives commands, read data, array results)
//   slave  : tpu_tile_sequencer (drives status, addresses, C writes, local buffers)
interface tpu_tile_sequencer_if #(
    parameter int unsigned SA_DIM    = 4,
    parameter int unsigned DATA_BITS = 8 * SA_DIM,
    parameter int unsigned ACC_BITS  = 32 * SA_DIM,
    parameter int unsigned ADDR_BITS = 16
);
    logic                          in_valid;
    logic [7:0]                    K;
    logic [7:0]                    M;
    logic [7:0]                    N;
    logic                          busy;
    logic                          done;
    logic                          sa_rst_n;
    logic                          sa_done;
    logic [ADDR_BITS-1:0]          A_index;
    logic [DATA_BITS-1:0]          A_data_out;
    logic [ADDR_BITS-1:0]          B_index;
    logic [DATA_BITS-1:0]          B_data_out;
    logic                          C_wr_en;
    logic [ADDR_BITS-1:0]          C_index;
    logic [ACC_BITS-1:0]           C_data_in;
    logic [SA_DIM*DATA_BITS-1:0]   local_buffer_A;
    logic [SA_DIM*DATA_BITS-1:0]   local_buffer_B;
    logic [SA_DIM*ACC_BITS-1:0]    sa_result;

    modport master (
        output in_valid, K, M, N, sa_done, A_data_out, B_data_out, sa_result,
        input  busy, done, sa_rst_n, A_index, B_index, C_wr_en, C_index, C_data_in,
               local_buffer_A, local_buffer_B
    );

    modport slave (
        input  in_valid, K, M, N, sa_done, A_data_out, B_data_out, sa_result,
        output busy, done, sa_rst_n, A_index, B_index, C_wr_en, C_index, C_data_in,
               local_buffer_A, local_buffer_B
    );
endinterface

// File: rtl/tpu_tile_sequencer.sv
// Tiles a K x M by K x N matmul onto an SA_DIM x SA_DIM systolic array.
// Loads A/B operand tiles (zero-padding the K edge), runs the array, accumulates
// partial sums over K tiles, then writes the finished C tile (skipping padded rows).
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - slave modport: command/status, A/B read ports, C write port, array side
module tpu_tile_sequencer #(
    parameter int unsigned SA_DIM    = 4,
    parameter int unsigned DATA_BITS = 8 * SA_DIM,
    parameter int unsigned ACC_BITS  = 32 * SA_DIM,
    parameter int unsigned ADDR_BITS = 16
) (
    input logic                 clk,
    input logic                 rst,
    tpu_tile_sequencer_if.slave bus
);
    localparam int unsigned Log2Sa = $clog2(SA_DIM);
    localparam int unsigned Cw     = $clog2(SA_DIM + 1);
    localparam int unsigned Lanes  = ACC_BITS / 32;

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StAcc, StWrite, StNext} state_e;

    state_e                            state_q, state_d;
    logic [Cw-1:0]                     c_q, c_d;   // LOAD word / WRITE row counter
    logic [7:0]                        kt_q, kt_d, mt_q, mt_d, nt_q, nt_d;
    logic [7:0]                        k_q, k_d, m_q, m_d, n_q, n_d;
    logic [SA_DIM-1:0][DATA_BITS-1:0]  buf_a_q, buf_a_d, buf_b_q, buf_b_d;
    logic [SA_DIM-1:0][ACC_BITS-1:0]   acc_q, acc_d;

    // Last tile index per dimension; only meaningful once nonzero dims are latched.
    logic [8:0] kt_last, mt_last, nt_last;
    logic       kt_at_last, mt_at_last, nt_at_last;

    assign kt_last    = (({1'b0, k_q} + 9'(SA_DIM - 1)) >> Log2Sa) - 9'd1;
    assign mt_last    = (({1'b0, m_q} + 9'(SA_DIM - 1)) >> Log2Sa) - 9'd1;
    assign nt_last    = (({1'b0, n_q} + 9'(SA_DIM - 1)) >> Log2Sa) - 9'd1;
    assign kt_at_last = ({1'b0, kt_q} == kt_last);
    assign mt_at_last = ({1'b0, mt_q} == mt_last);
    assign nt_at_last = ({1'b0, nt_q} == nt_last);

    // Outputs
    always_comb begin
        bus.busy           = (state_q != StIdle);
        bus.done           = (state_q == StNext) && mt_at_last && nt_at_last;
        bus.sa_rst_n       = (state_q == StRun);
        bus.A_index        = ADDR_BITS'(32'(mt_q) * 32'(k_q) + 32'(kt_q) * SA_DIM + 32'(c_q));
        bus.B_index        = ADDR_BITS'(32'(nt_q) * 32'(k_q) + 32'(kt_q) * SA_DIM + 32'(c_q));
        bus.C_index        = ADDR_BITS'(32'(nt_q) * 32'(m_q) + 32'(mt_q) * SA_DIM + 32'(c_q));
        bus.C_wr_en        = 1'b0;
        bus.C_data_in      = '0;
        bus.local_buffer_A = buf_a_q;
        bus.local_buffer_B = buf_b_q;
        if (state_q == StWrite) begin
            for (int i = 0; i < int'(SA_DIM); i++) begin
                if (c_q == Cw'(i)) bus.C_data_in = acc_q[i];
            end
            // Rows past M belong to the padded edge tile and are not written.
            bus.C_wr_en = (32'(mt_q) * SA_DIM + 32'(c_q)) < 32'(m_q);
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        kt_d    = kt_q;
        mt_d    = mt_q;
        nt_d    = nt_q;
        k_d     = k_q;
        m_d     = m_q;
        n_d     = n_q;
        buf_a_d = buf_a_q;
        buf_b_d = buf_b_q;
        acc_d   = acc_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid && (bus.K != 8'd0) && (bus.M != 8'd0) && (bus.N != 8'd0)) begin
                    k_d     = bus.K;
                    m_d     = bus.M;
                    n_d     = bus.N;
                    c_d     = '0;
                    kt_d    = '0;
                    mt_d    = '0;
                    nt_d    = '0;
                    acc_d   = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                // Read data lags the address by one cycle: cycle c captures word c-1.
                for (int i = 0; i < int'(SA_DIM); i++) begin
                    if (c_q == Cw'(i + 1)) begin
                        if ((32'(kt_q) * SA_DIM + 32'(i)) < 32'(k_q)) begin
                            buf_a_d[i] = bus.A_data_out;
                            buf_b_d[i] = bus.B_data_out;
                        end else begin
                            buf_a_d[i] = '0;
                            buf_b_d[i] = '0;
                        end
                    end
                end
                if (c_q == Cw'(SA_DIM)) begin
                    c_d     = '0;
                    state_d = StRun;
                end else begin
                    c_d = c_q + Cw'(1);
                end
            end
            StRun: begin
                if (bus.sa_done) state_d = StAcc;
            end
            StAcc: begin
                for (int r = 0; r < int'(SA_DIM); r++) begin
                    for (int l = 0; l < int'(Lanes); l++) begin
                        acc_d[r][l*32 +: 32] = acc_q[r][l*32 +: 32]
                                             + bus.sa_result[r*ACC_BITS + l*32 +: 32];
                    end
                end
                if (kt_at_last) begin
                    c_d     = '0;
                    state_d = StWrite;
                end else begin
                    kt_d    = kt_q + 8'd1;
                    state_d = StLoad;
                end
            end
            StWrite: begin
                if (c_q == Cw'(SA_DIM - 1)) begin
                    c_d     = '0;
                    state_d = StNext;
                end else begin
                    c_d = c_q + Cw'(1);
                end
            end
            StNext: begin
                acc_d = '0;
                kt_d  = '0;
                if (!mt_at_last) begin
                    mt_d    = mt_q + 8'd1;
                    state_d = StLoad;
                end else if (!nt_at_last) begin
                    mt_d    = '0;
                    nt_d    = nt_q + 8'd1;
                    state_d = StLoad;
                end else begin
                    // Park counters at zero so idle addresses read as 0.
                    mt_d    = '0;
                    nt_d    = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            c_q     <= '0;
            kt_q    <= '0;
            mt_q    <= '0;
            nt_q    <= '0;
            k_q     <= '0;
            m_q     <= '0;
            n_q     <= '0;
            buf_a_q <= '0;
            buf_b_q <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            kt_q    <= kt_d;
            mt_q    <= mt_d;
            nt_q    <= nt_d;
            k_q     <= k_d;
            m_q     <= m_d;
            n_q     <= n_d;
            buf_a_q <= buf_a_d;
            buf_b_q <= buf_b_d;
            acc_q   <= acc_d;
        end
    end
endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Self-checking bench for tpu_tile_sequencer: table of jobs on an SA_DIM=4 instance,
// plus hand sequences for ignored commands, reset mid-job and an SA_DIM=8 instance.
module tb_tpu_tile_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    tpu_tile_sequencer_if #(.SA_DIM(4)) bus4 ();
    tpu_tile_sequencer_if #(.SA_DIM(8)) bus8 ();

    tpu_tile_sequencer #(.SA_DIM(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
    tpu_tile_sequencer #(.SA_DIM(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

    // Global-buffer contents: every word nonzero so padding is visible.
    function automatic logic [31:0] mem_a4(input logic [15:0] a);
        return {a[7:0] + 8'd1, 8'hFF, a[7:0], 8'hA5};
    endfunction
    function automatic logic [31:0] mem_b4(input logic [15:0] a);
        return {8'h5A, a[7:0], 8'hFF, a[7:0] ^ 8'h3C};
    endfunction

    // 1-cycle synchronous read buffers
    always @(posedge clk) begin
        bus4.A_data_out <= mem_a4(bus4.A_index);
        bus4.B_data_out <= mem_b4(bus4.B_index);
        bus8.A_data_out <= {8{bus8.A_index[7:0] + 8'd1}};
        bus8.B_data_out <= {8{bus8.B_index[7:0] + 8'h10}};
    end

    // Array model: sa_done in the trun-th RUN cycle.
    int unsigned trun4 = 5, trun8 = 5, run_cnt4 = 0, run_cnt8 = 0;
    always @(negedge clk) begin
        if (bus4.sa_rst_n === 1'b1) run_cnt4 = run_cnt4 + 1;
        else run_cnt4 = 0;
        bus4.sa_done = (run_cnt4 != 0) && (run_cnt4 >= trun4);
        if (bus8.sa_rst_n === 1'b1) run_cnt8 = run_cnt8 + 1;
        else run_cnt8 = 0;
        bus8.sa_done = (run_cnt8 != 0) && (run_cnt8 >= trun8);
    end

    task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic fail(input string nm, input int got, input int exp);
        checks++;
        failures++;
        $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    typedef struct {
        int k;
        int m;
        int n;
        int trun;
        int base;        // sa_result lane value for row 0
        bit ramp;        // row r lanes = base + r when set, else all = base
        bit poke;        // issue a K=8 command on first RUN entry
        int exp_writes;
        int exp_cycles;
    } vec_t;

    vec_t vecs[6];

    task automatic run_job4(input vec_t v);
        int              kt_n, mt_n, nt_n, writes, cycles, pos, row;
        bit              seen_done, in_run, poked;
        logic [127:0]    wa, wb, d;
        logic [127:0]    exp_a[$], exp_b[$], exp_d[$];
        int              exp_idx[$];
        kt_n = (v.k + 3) / 4;
        mt_n = (v.m + 3) / 4;
        nt_n = (v.n + 3) / 4;
        for (int nt = 0; nt < nt_n; nt++) begin
            for (int mt = 0; mt < mt_n; mt++) begin
                for (int kt = 0; kt < kt_n; kt++) begin
                    for (int c = 0; c < 4; c++) begin
                        pos = kt * 4 + c;
                        wa[c*32 +: 32] = (pos < v.k) ? mem_a4(16'(mt * v.k + pos)) : 32'd0;
                        wb[c*32 +: 32] = (pos < v.k) ? mem_b4(16'(nt * v.k + pos)) : 32'd0;
                    end
                    exp_a.push_back(wa);
                    exp_b.push_back(wb);
                end
                for (int j = 0; j < 4; j++) begin
                    row = mt * 4 + j;
                    if (row < v.m) begin
                        for (int l = 0; l < 4; l++)
                            d[l*32 +: 32] = 32'(kt_n * (v.base + (v.ramp ? j : 0)));
                        exp_idx.push_back(nt * v.m + row);
                        exp_d.push_back(d);
                    end
                end
            end
        end
        for (int r = 0; r < 4; r++)
            for (int l = 0; l < 4; l++)
                bus4.sa_result[r*128 + l*32 +: 32] = 32'(v.base + (v.ramp ? r : 0));
        trun4 = v.trun;
        writes = 0; cycles = 0; seen_done = 0; in_run = 0; poked = 0;
        @(negedge clk);
        bus4.K = 8'(v.k);
        bus4.M = 8'(v.m);
        bus4.N = 8'(v.n);
        bus4.in_valid = 1'b1;
        for (int cyc = 1; cyc <= 2000 && !seen_done; cyc++) begin
            @(negedge clk);
            bus4.in_valid = 1'b0;
            if (bus4.busy) cycles++;
            if (cyc <= 4) begin
                chk("a_index_first_load", bus4.A_index, 16'(cyc - 1));
                chk("b_index_first_load", bus4.B_index, 16'(cyc - 1));
            end
            if (bus4.sa_rst_n && !in_run) begin
                if (exp_a.size() == 0) fail("extra_run_entry", 1, 0);
                else begin
                    chk("local_buffer_A", bus4.local_buffer_A, exp_a.pop_front());
                    chk("local_buffer_B", bus4.local_buffer_B, exp_b.pop_front());
                end
                if (v.poke && !poked) begin
                    bus4.K = 8'd8;
                    bus4.in_valid = 1'b1;
                    poked = 1;
                end
            end
            in_run = bus4.sa_rst_n;
            if (bus4.C_wr_en) begin
                writes++;
                if (exp_idx.size() == 0) fail("extra_c_write", int'(bus4.C_index), -1);
                else begin
                    chk("c_index", bus4.C_index, 16'(exp_idx.pop_front()));
                    chk("c_data", bus4.C_data_in, exp_d.pop_front());
                end
            end
            if (bus4.done) seen_done = 1;
        end
        if (!seen_done) fail("done_timeout", 0, 1);
        chk("write_count", writes, v.exp_writes);
        chk("busy_cycles", cycles, v.exp_cycles);
        chk("tiles_loaded", exp_a.size(), 0);
        @(negedge clk);
        chk("busy_after_done", bus4.busy, 0);
        chk("done_single_pulse", bus4.done, 0);
    endtask

    initial begin
        int        load_cycles, writes8, cycles8;
        bit        seen8, run_seen8;
        logic [511:0] e8;
        int        zk[3], zm[3], zn[3];

        bus4.in_valid = 0; bus4.K = 0; bus4.M = 0; bus4.N = 0; bus4.sa_result = '0;
        bus8.in_valid = 0; bus8.K = 0; bus8.M = 0; bus8.N = 0; bus8.sa_result = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus4.busy, 0);
        chk("rst_done", bus4.done, 0);
        chk("rst_sa_rst_n", bus4.sa_rst_n, 0);
        chk("rst_c_wr_en", bus4.C_wr_en, 0);
        chk("rst_a_index", bus4.A_index, 0);
        chk("rst_c_index", bus4.C_index, 0);
        chk("rst_c_data", bus4.C_data_in, 0);
        chk("rst_local_a", bus4.local_buffer_A, 0);
        rst = 1'b0;

        //          k  m  n trun base ramp poke writes cycles
        vecs[0] = '{4, 4, 4, 5,   1,   1,   0,   4,     16};
        vecs[1] = '{8, 4, 4, 3,   1,   0,   0,   4,     23};
        vecs[2] = '{6, 4, 4, 2,   3,   1,   0,   4,     21};
        vecs[3] = '{4, 6, 8, 2,   7,   1,   0,   12,    52};
        vecs[4] = '{4, 4, 4, 6,   2,   1,   1,   4,     17};
        vecs[5] = '{1, 1, 1, 1,   9,   0,   0,   1,     12};
        for (int i = 0; i < 6; i++) run_job4(vecs[i]);

        // Commands with a zero dimension are ignored.
        zk = '{0, 4, 4}; zm = '{4, 0, 4}; zn = '{4, 4, 0};
        for (int i = 0; i < 3; i++) begin
            bus4.K = 8'(zk[i]); bus4.M = 8'(zm[i]); bus4.N = 8'(zn[i]);
            bus4.in_valid = 1'b1;
            @(negedge clk);
            bus4.in_valid = 1'b0;
            chk("zero_dim_ignored", bus4.busy, 0);
        end

        // Reset in the middle of RUN, then a clean job.
        trun4 = 1000;
        bus4.K = 8'd4; bus4.M = 8'd4; bus4.N = 8'd4;
        bus4.in_valid = 1'b1;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        for (int i = 0; i < 50 && !bus4.sa_rst_n; i++) @(negedge clk);
        if (!bus4.sa_rst_n) fail("run_entry_timeout", 0, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", bus4.busy, 0);
        chk("midrst_c_wr_en", bus4.C_wr_en, 0);
        chk("midrst_sa_rst_n", bus4.sa_rst_n, 0);
        chk("midrst_local_a", bus4.local_buffer_A, 0);
        chk("midrst_local_b", bus4.local_buffer_B, 0);
        chk("midrst_a_index", bus4.A_index, 0);
        rst = 1'b0;
        run_job4(vecs[0]);

        // SA_DIM=8: LOAD lasts 9 cycles, WRITE 8.
        for (int r = 0; r < 8; r++)
            for (int l = 0; l < 8; l++)
                bus8.sa_result[r*256 + l*32 +: 32] = 32'd1;
        trun8 = 5;
        load_cycles = 0; writes8 = 0; cycles8 = 0; seen8 = 0; run_seen8 = 0;
        @(negedge clk);
        bus8.K = 8'd8; bus8.M = 8'd8; bus8.N = 8'd8;
        bus8.in_valid = 1'b1;
        for (int cyc = 1; cyc <= 500 && !seen8; cyc++) begin
            @(negedge clk);
            bus8.in_valid = 1'b0;
            if (bus8.busy) cycles8++;
            if (!run_seen8 && bus8.busy && !bus8.sa_rst_n) load_cycles++;
            if (bus8.sa_rst_n && !run_seen8) begin
                run_seen8 = 1;
                for (int c = 0; c < 8; c++) e8[c*64 +: 64] = {8{8'(c + 1)}};
                chk("sa8_local_a", bus8.local_buffer_A, e8);
                for (int c = 0; c < 8; c++) e8[c*64 +: 64] = {8{8'(c + 16)}};
                chk("sa8_local_b", bus8.local_buffer_B, e8);
            end
            if (bus8.C_wr_en) begin
                chk("sa8_c_index", bus8.C_index, 16'(writes8));
                chk("sa8_c_data", bus8.C_data_in, {8{32'd1}});
                writes8++;
            end
            if (bus8.done) seen8 = 1;
        end
        if (!seen8) fail("sa8_done_timeout", 0, 1);
        chk("sa8_load_cycles", load_cycles, 9);
        chk("sa8_write_count", writes8, 8);
        chk("sa8_busy_cycles", cycles8, 24);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tpu_tile_sequencer.md
Name: tpu_tile_sequencer

Overview:
Parametrised successor to the 4x4 TPU controller. It tiles a K x M by K x N matmul onto an SA_DIM x SA_DIM systolic array. It streams A/B operand tiles from the global buffers into the array's local buffers and accumulates partial sums across K tiles. It writes each finished C tile back, sitting between the host-facing buffers and the systolic array. New capabilities:
- arbitrary SA_DIM (power of 2)
- ceil-division tiling with zero padding on K and M edges
- pipelined operand load
- single clock edge
- done pulse
- rejection of illegal and busy-time commands

Parameters:
SA_DIM, 4, array dimension; power of 2, range 2..16
DATA_BITS, 8*SA_DIM, one A/B buffer word: SA_DIM packed int8 lanes
ACC_BITS, 32*SA_DIM, one C row: SA_DIM packed 32-bit lanes
ADDR_BITS, 16, buffer index width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  command strobe; K/M/N sampled when accepted
K  in  8  reduction depth
M  in  8  rows of C
N  in  8  columns of C
busy  out  1  high from accept until return to IDLE
done  out  1  one-cycle pulse on final transition to IDLE
sa_rst_n  out  1  array enable; 0 clears the array, 1 lets it run
sa_done  in  1  array finished the current tile
A_index  out  ADDR_BITS  A buffer read address; 1-cycle synchronous read
A_data_out  in  DATA_BITS  A read data
B_index  out  ADDR_BITS  B buffer read address
B_data_out  in  DATA_BITS  B read data
C_wr_en  out  1  C write strobe
C_index  out  ADDR_BITS  C write address
C_data_in  out  ACC_BITS  C write data
local_buffer_A  out  SA_DIM*DATA_BITS  A tile; word i at bits [i*DATA_BITS +: DATA_BITS]
local_buffer_B  out  SA_DIM*DATA_BITS  B tile, same packing
sa_result  in  SA_DIM*ACC_BITS  array output rows; row r at [r*ACC_BITS +: ACC_BITS]

Behaviour:
- Reset (rst=1 at clk edge), regardless of current state:
  - state=IDLE
  - busy, done, C_wr_en, sa_rst_n = 0
  - A_index, B_index, C_index, C_data_in = 0
  - local buffers, accumulators, all counters = 0
- Tile counts: KT=ceil(K/SA_DIM), MT=ceil(M/SA_DIM), NT=ceil(N/SA_DIM). Counters kt, mt, nt; loop order is kt innermost, then mt, then nt.
- Addressing:
  - A_index = mt*K + kt*SA_DIM + c
  - B_index = nt*K + kt*SA_DIM + c
  - C_index = nt*M + mt*SA_DIM + j
  - A_index and B_index are combinational from counters.
- State IDLE: busy=0.
  - in_valid with K, M and N all nonzero: latch dims, zero counters and accumulators, go to LOAD.
  - in_valid with any dim equal to 0: ignored.
- State LOAD (SA_DIM+1 cycles, c=0..SA_DIM):
  - For c<SA_DIM, issue address c.
  - For c>=1, capture word c-1. Captured value is the read data if kt*SA_DIM+(c-1)<K, else 0 (K-edge padding).
  - After c=SA_DIM, go to RUN. sa_rst_n=0 throughout.
- State RUN: sa_rst_n=1; wait for sa_done, then go to ACC. There is no timeout.
- State ACC (1 cycle): sa_rst_n=0.
  - Each 32-bit lane: acc[r] += sa_result row r, wrapping modulo 2^32 per lane.
  - If kt==KT-1, go to WRITE with j=0; else kt++ and go to LOAD.
- State WRITE (SA_DIM cycles, j=0..SA_DIM-1):
  - C_data_in=acc[j].
  - C_wr_en=1 only if mt*SA_DIM+j<M; padded rows are suppressed.
  - After j=SA_DIM-1, go to NEXT.
- State NEXT (1 cycle): clear accumulators, kt=0.
  - If mt<MT-1: mt++, go to LOAD.
  - Else if nt<NT-1: mt=0, nt++, go to LOAD.
  - Else: go to IDLE and assert done for this one cycle.
- Padding outside the sequencer: lane padding inside a word (M/N edge columns) is the producer's job; it writes zeros.
- busy is 1 in every non-IDLE state.
- in_valid while busy is ignored; latched dims are unchanged.
- sa_done outside RUN is ignored.
- Timing, no stalls: cycles per job = MT*NT*(KT*(SA_DIM+2+Trun) + SA_DIM + 1), where Trun = RUN cycles including the sa_done cycle.

Test Plan:
1. SA_DIM=4, K=M=N=4, A=B=identity words, sa_done 5 cycles after RUN entry:
   - A_index sequence 0,1,2,3; single ACC.
   - 4 C writes at indices 0..3 with sa_result rows.
   - done pulses once; busy low next cycle.
2. K=8, M=N=4, sa_result constant 1 per lane in both K tiles:
   - KT=2, LOAD entered twice (A_index 0..3 then 4..7).
   - All C lanes =2.
3. K=6, M=N=4:
   - Second LOAD captures words 4,5 from buffer and words 6,7 as zero regardless of A_data_out=0xFFFFFFFF.
4. K=4, M=6, N=8:
   - MT=2, NT=2; C writes at indices 0..3, 4,5, 6..9, 10,11.
   - Rows 6,7 of each second M tile have C_wr_en=0; total 12 writes; one done.
5. Second in_valid with K=8 during RUN of a K=4 job:
   - Ignored; exactly KT=1 per tile; C matches K=4 result.
6. rst asserted during RUN of any job, and SA_DIM=8 rerun of scenario 1:
   - After rst: state IDLE, busy=0, C_wr_en=0, local buffers 0; a new command completes correctly.
   - SA_DIM=8 rerun: LOAD lasts 9 cycles and WRITE lasts 8.
